// File: rtl/shift_cmd_sequencer_pkg.sv
// rtl/shift_cmd_sequencer_pkg.sv - shared mode encodings, FSM states and default sizes
package shift_seq_defs;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 4;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_cmd_sequencer_if.sv
// rtl/shift_cmd_sequencer_if.sv - command handshake and shift-register drive bundle (abort lines under SHIFT_SEQ_ABORT_EN)
interface shift_cmd_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic [2:0]       sr_S;
  logic [WIDTH-1:0] sr_I;
  logic             busy;
  logic             done;
`ifdef SHIFT_SEQ_ABORT_EN
  logic             abort;
  logic             aborted;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_count, cmd_data, abort,
    output cmd_ready, sr_S, sr_I, busy, done, aborted
  );
  modport master (
    output cmd_valid, cmd_mode, cmd_count, cmd_data, abort,
    input  cmd_ready, sr_S, sr_I, busy, done, aborted
  );
`else
  modport slave (
    input  cmd_valid, cmd_mode, cmd_count, cmd_data,
    output cmd_ready, sr_S, sr_I, busy, done
  );
  modport master (
    output cmd_valid, cmd_mode, cmd_count, cmd_data,
    input  cmd_ready, sr_S, sr_I, busy, done
  );
`endif
endinterface

// File: rtl/shift_cmd_sequencer_counter.sv
// rtl/shift_cmd_sequencer_counter.sv - run-length down-counter with load, enable and last flag
module shift_cycle_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at 1 so a stray enable can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q > CNT_W'(1))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign last  = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/shift_cmd_sequencer.sv
// rtl/shift_cmd_sequencer.sv - command-driven mode sequencer for a universal shift register
// Optional abort input/aborted output enabled by SHIFT_SEQ_ABORT_EN.
module shift_cmd_sequencer
  import shift_seq_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   clear,
  shift_cmd_sequencer_if.slave   bus
);
  seq_state_t       state_q, state_d;
  logic [2:0]       sr_s_q, sr_s_d;
  logic [WIDTH-1:0] sr_i_q, sr_i_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             aborted_q, aborted_d;

  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt_count;
  logic             cnt_last;
  logic             accept;

  assign accept = bus.cmd_valid && ready_q;

  shift_cycle_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clk),
    .rst      (clear),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .count    (cnt_count),
    .last     (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    sr_s_d    = sr_s_q;
    sr_i_d    = sr_i_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_val   = bus.cmd_count;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        sr_s_d  = MODE_HOLD;
        busy_d  = 1'b0;
        if (accept) begin
          if (bus.cmd_mode == MODE_LOAD) begin
            // LOAD always runs for a single cycle whatever count says.
            state_d  = ST_RUN;
            sr_s_d   = MODE_LOAD;
            sr_i_d   = bus.cmd_data;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(1);
          end else if (bus.cmd_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_RUN;
            sr_s_d   = bus.cmd_mode;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
`ifdef SHIFT_SEQ_ABORT_EN
        if (bus.abort) begin
          state_d   = ST_DONE;
          sr_s_d    = MODE_HOLD;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else
`endif
        if (cnt_last) begin
          state_d = ST_DONE;
          sr_s_d  = MODE_HOLD;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sr_s_d  = MODE_HOLD;
        busy_d  = 1'b0;
      end
    endcase

    ready_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      sr_s_q    <= MODE_HOLD;
      sr_i_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_s_q    <= sr_s_d;
      sr_i_q    <= sr_i_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.sr_S      = sr_s_q;
  assign bus.sr_I      = sr_i_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef SHIFT_SEQ_ABORT_EN
  assign bus.aborted   = aborted_q;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, aborted_q, cnt_count};
`endif
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// tb/tb_shift_cmd_sequencer.sv - scoreboard bench for shift_cmd_sequencer
module tb_shift_cmd_sequencer;
  import shift_seq_defs::*;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  shift_cmd_sequencer_if #(.WIDTH(4), .CNT_W(4)) bus ();

  shift_cmd_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [2:0] s;
    logic [3:0] i;
    logic       busy;
    logic       done;
    logic       ready;
    logic       ab;
  } rec_t;

  rec_t       exp_q[$];
  int         n_checks = 0;
  int         n_err = 0;
  logic [3:0] exp_i;

  function automatic logic get_aborted();
`ifdef SHIFT_SEQ_ABORT_EN
    return bus.aborted;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push(input logic [2:0] s, input logic [3:0] i, input logic b,
                      input logic d, input logic r, input logic ab);
    rec_t e;
    e.s = s; e.i = i; e.busy = b; e.done = d; e.ready = r; e.ab = ab;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT shows activity consumes one expected record.
  always @(negedge clk) begin
    if (!clear && (bus.busy || bus.done)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_cycle: got sr_S=%b sr_I=%b busy=%b done=%b, expected no activity",
                 bus.sr_S, bus.sr_I, bus.busy, bus.done);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        if (bus.sr_S !== e.s || bus.sr_I !== e.i || bus.busy !== e.busy ||
            bus.done !== e.done || bus.cmd_ready !== e.ready || get_aborted() !== e.ab) begin
          n_err++;
          $display("FAIL cycle_rec: got sr_S=%b sr_I=%b busy=%b done=%b ready=%b aborted=%b, expected sr_S=%b sr_I=%b busy=%b done=%b ready=%b aborted=%b",
                   bus.sr_S, bus.sr_I, bus.busy, bus.done, bus.cmd_ready, get_aborted(),
                   e.s, e.i, e.busy, e.done, e.ready, e.ab);
        end
      end
    end
  end

  task automatic chk_reset(input string name);
    n_checks++;
    if (bus.sr_S !== MODE_HOLD || bus.sr_I !== 4'b0000 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s: got sr_S=%b sr_I=%b busy=%b done=%b ready=%b, expected 000 0000 0 0 1",
               name, bus.sr_S, bus.sr_I, bus.busy, bus.done, bus.cmd_ready);
    end
  endtask

  task automatic send_raw(input logic [2:0] m, input logic [3:0] c, input logic [3:0] d,
                          input bit keep);
    bit acc;
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    bus.cmd_count = c;
    bus.cmd_data  = d;
    for (int k = 0; k < 50; k++) begin
      acc = bus.cmd_ready;
      @(posedge clk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: got cmd_ready=0 for 50 cycles, expected accept");
    end
    if (!keep) begin
      #1;
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [2:0] m, input logic [3:0] c, input logic [3:0] d,
                      input bit keep);
    send_raw(m, c, d, keep);
    if (m == MODE_LOAD) begin
      exp_i = d;
      push(MODE_LOAD, exp_i, 1'b1, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int k = 0; k < int'(c); k++) push(m, exp_i, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    push(MODE_HOLD, exp_i, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy && !bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d records still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_i         = 4'b0000;
    clear         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = MODE_HOLD;
    bus.cmd_count = 4'd0;
    bus.cmd_data  = 4'd0;
`ifdef SHIFT_SEQ_ABORT_EN
    bus.abort     = 1'b0;
`endif
    #3;
    chk_reset("reset_initial");
    #9 clear = 1'b0;

    send(MODE_LOAD, 4'd7, 4'b1001, 1'b0);
    drain("drain_load");

    send(MODE_ROR, 4'd3, 4'b0000, 1'b0);
    drain("drain_ror");

    send(MODE_SHL, 4'd0, 4'b0000, 1'b1);
    send(MODE_SHR, 4'd2, 4'b0000, 1'b0);
    drain("drain_b2b");

    send(MODE_HOLD, 4'd2, 4'b0000, 1'b0);
    drain("drain_hold_wait");

    send(MODE_SHL, 4'd15, 4'b0000, 1'b0);
    drain("drain_max_count");

    // Reset in the middle of a run: only four active ROL cycles, no done.
    send_raw(MODE_ROL, 4'd10, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) push(MODE_ROL, exp_i, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 clear = 1'b1;
    #1 chk_reset("reset_mid_run");
    exp_i = 4'b0000;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rol_cycles: got %0d records unconsumed, expected 0", exp_q.size());
      exp_q.delete();
    end
    #10 clear = 1'b0;
    repeat (3) @(negedge clk);

    send(MODE_LOAD, 4'd0, 4'b0110, 1'b0);
    drain("drain_after_reset");

`ifdef SHIFT_SEQ_ABORT_EN
    send_raw(MODE_ASR, 4'd8, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) push(MODE_ASR, exp_i, 1'b1, 1'b0, 1'b0, 1'b0);
    push(MODE_HOLD, exp_i, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    drain("drain_abort");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
